// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-master round-robin arbiter for a shared req/ack memory port
module mem_port_arbiter #(
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_done,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic          owner;
    logic          last;
    logic [CW-1:0] cnt;

    logic          grant;
    logic          grant_sel;
    logic          finish;
    logic          timed_out;

    always_comb begin
        state_nx  = state;
        grant     = 1'b0;
        grant_sel = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant     = 1'b1;
                    // On contention the master that did not own the last transaction wins
                    grant_sel = (m0_req && m1_req) ? ~last : m1_req;
                    state_nx  = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end else if (cnt >= CNT_LAST) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_done   <= 1'b0;
            m1_done   <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state   <= state_nx;
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            m0_err  <= 1'b0;
            m1_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner     <= grant_sel;
                        m0_gnt    <= ~grant_sel;
                        m1_gnt    <= grant_sel;
                        mem_req   <= 1'b1;
                        mem_we    <= grant_sel ? m1_we    : m0_we;
                        mem_addr  <= grant_sel ? m1_addr  : m0_addr;
                        mem_wdata <= grant_sel ? m1_wdata : m0_wdata;
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    if (!mem_ack && cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (finish) begin
                        mem_req <= 1'b0;
                        if (owner) begin
                            m1_done <= 1'b1;
                            m1_err  <= timed_out;
                        end else begin
                            m0_done <= 1'b1;
                            m0_err  <= timed_out;
                        end
                        // A timed-out read returns zero so stale data is never mistaken for a result
                        if (timed_out) begin
                            if (owner) m1_rdata <= '0;
                            else       m0_rdata <= '0;
                        end else if (!mem_we) begin
                            if (owner) m1_rdata <= mem_rdata;
                            else       m0_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    last   <= owner;
                    m0_gnt <= 1'b0;
                    m1_gnt <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW      = 64;
    localparam int DW      = 64;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m1_req, m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic          req   [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];

    assign m0_req = req[0];   assign m1_req = req[1];
    assign m0_we = we[0];     assign m1_we = we[1];
    assign m0_addr = addr[0]; assign m1_addr = addr[1];
    assign m0_wdata = wdata[0]; assign m1_wdata = wdata[1];

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owned the last completed transaction and each master's visible rdata
    int            model_last;
    logic [DW-1:0] exp_rd [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic new_params(input int m);
        we[m]    = 1'($urandom_range(0, 1));
        addr[m]  = {$urandom, $urandom};
        wdata[m] = {$urandom, $urandom};
    endtask

    task automatic start_if_idle();
        int p;
        if (!req[0] && !req[1]) begin
            p = $urandom_range(1, 3);
            if (p[0]) begin new_params(0); req[0] = 1'b1; end
            if (p[1]) begin new_params(1); req[1] = 1'b1; end
        end
    endtask

    // Called at a negedge in IDLE with at least one request raised; returns at the following IDLE negedge
    task automatic run_txn(input int lat, input bit mutate, input bit rereq, input bit start_other,
                           output int win);
        int            w, k, nreq, oth;
        bit            held, exp_err;
        logic [1:0]    exp_g;
        logic [DW-1:0] rd, d_exp;
        logic [AW-1:0] a_exp;
        logic          we_exp;

        win    = (req[0] && req[1]) ? 1 - model_last : (req[1] ? 1 : 0);
        oth    = 1 - win;
        exp_g  = (win == 1) ? 2'b10 : 2'b01;
        a_exp  = addr[win];
        d_exp  = wdata[win];
        we_exp = we[win];

        w = 0;
        while (!mem_req && w < 8) begin @(negedge clk); w++; end
        check("grant_latency", 64'(w), 64'd1);
        check("gnt", {m1_gnt, m0_gnt}, exp_g);
        check("mem_addr", mem_addr, a_exp);
        check("mem_wdata", mem_wdata, d_exp);
        check("mem_we", mem_we, we_exp);

        rd = {$urandom, $urandom};
        k = 0; nreq = 0; held = 1'b1;
        while (mem_req && nreq < TIMEOUT + 10) begin
            if (mem_addr !== a_exp || mem_wdata !== d_exp || mem_we !== we_exp ||
                {m1_gnt, m0_gnt} !== exp_g || (m0_done | m1_done) !== 1'b0) held = 1'b0;
            mem_ack   = (k == lat);
            mem_rdata = rd;
            if (mutate && k == 0) begin
                addr[win]  = ~addr[win];
                wdata[win] = ~wdata[win];
                we[win]    = ~we[win];
                req[win]   = 1'b0;
            end
            @(negedge clk);
            k++; nreq++;
        end
        mem_ack = 1'b0;

        exp_err = (lat >= TIMEOUT);
        if (exp_err)      exp_rd[win] = '0;
        else if (!we_exp) exp_rd[win] = rd;

        check("busy_hold", held, 1'b1);
        check("req_cycles", 64'(nreq), 64'((lat < TIMEOUT) ? lat + 1 : TIMEOUT));
        check("done", {m1_done, m0_done}, exp_g);
        check("err", {m1_err, m0_err}, exp_err ? exp_g : 2'b00);
        check("gnt_in_done", {m1_gnt, m0_gnt}, exp_g);
        check("m0_rdata", m0_rdata, exp_rd[0]);
        check("m1_rdata", m1_rdata, exp_rd[1]);
        model_last = win;

        if (rereq && req[win]) new_params(win);
        else                   req[win] = 1'b0;
        if (start_other && !req[oth]) begin new_params(oth); req[oth] = 1'b1; end

        // A stray ack outside BUSY must not disturb anything
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = ~rd;
        @(negedge clk);
        check("idle_gnt", {m1_gnt, m0_gnt}, 2'b00);
        check("idle_done", {m1_done, m0_done, m1_err, m0_err}, 4'b0000);
        check("idle_rdata", (m0_rdata === exp_rd[0]) && (m1_rdata === exp_rd[1]), 1'b1);
        mem_ack = 1'b0;
        start_if_idle();
    endtask

    initial begin
        int win, lat, w;
        int dir_lat [4];

        reset = 1'b1;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; we[m] = 1'b0; addr[m] = '0; wdata[m] = '0; exp_rd[m] = '0;
        end
        model_last = 1;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, mem_req, mem_we}, 8'h00);
        check("rst_data", |{mem_addr, mem_wdata, m0_rdata, m1_rdata}, 1'b0);
        reset = 1'b0;

        // Continuous contention against zero-wait memory: strict alternation starting with m0
        new_params(0); new_params(1);
        req[0] = 1'b1; req[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_txn(0, 1'b0, 1'b1, 1'b1, win);
            check("rr_order", 64'(win), 64'(i % 2));
        end
        req[0] = 1'b0; req[1] = 1'b0;
        @(negedge clk);

        // Single m0 read of 0x40 with two wait states
        we[0] = 1'b0; addr[0] = 64'h40; wdata[0] = '0; req[0] = 1'b1;
        run_txn(2, 1'b0, 1'b0, 1'b0, win);
        check("single_m1_quiet", {m1_gnt, m1_done, m1_err}, 3'b000);

        // Timeout boundaries: no ack, ack on the last allowed cycle, ack one cycle too late
        dir_lat[0] = TIMEOUT + 3; dir_lat[1] = TIMEOUT - 1; dir_lat[2] = TIMEOUT; dir_lat[3] = 1;
        for (int i = 0; i < 4; i++) begin
            run_txn(dir_lat[i], 1'b0, 1'b0, 1'b1, win);
        end

        // Master abandons its request and changes its inputs mid-transaction
        run_txn(3, 1'b1, 1'b0, 1'b1, win);

        for (int i = 0; i < 60; i++) begin
            lat = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3)
                                              : $urandom_range(0, 4);
            run_txn(lat, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 2) == 0, win);
        end

        // Reset in the middle of a transaction
        w = 0;
        while (!mem_req && w < 8) begin @(negedge clk); w++; end
        check("pre_reset_busy", mem_req, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("midrst_ctrl", {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, mem_req, mem_we}, 8'h00);
        check("midrst_data", |{mem_addr, mem_wdata, m0_rdata, m1_rdata}, 1'b0);
        repeat (3) @(negedge clk);
        check("midrst_no_done", {m0_done, m1_done}, 2'b00);
        model_last = 1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        new_params(0); new_params(1);
        req[0] = 1'b1; req[1] = 1'b1;
        reset = 1'b0;
        run_txn(2, 1'b0, 1'b0, 1'b0, win);
        check("post_rst_first", 64'(win), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter that shares the single unified instruction/data memory port of the multi-cycle MIPS core between the core (master 0) and a program loader/DMA engine (master 1). It serialises one transaction at a time onto a variable-latency req/ack memory interface and round-robins between the two masters. It latches each read result and flags timeouts so a hung memory cannot deadlock the core's state machine.

## Interface
- AW, 64, address width
- DW, 64, data width
- TIMEOUT, 15, max cycles mem_req may stay high without mem_ack before abort (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- m0_req / m1_req  in  1  master n requests a transaction (level)
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  AW  byte address
- m0_wdata / m1_wdata  in  DW  write data
- m0_gnt / m1_gnt  out  1  master n owns the memory port
- m0_done / m1_done  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  one-cycle pulse with done: transaction timed out
- m0_rdata / m1_rdata  out  DW  registered read data, held until the next done for that master
- mem_req  out  1  transaction request to memory
- mem_we  out  1  write enable to memory
- mem_addr  out  AW  address to memory
- mem_wdata  out  DW  write data to memory
- mem_rdata  in  DW  read data, valid when mem_ack = 1
- mem_ack  in  1  memory completion, one cycle

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant the master that did not own the last transaction. After reset, master 0 has priority.
- On grant (IDLE→BUSY):
  - latch the winner's we/addr/wdata into the mem_* registers;
  - set owner and mX_gnt;
  - clear the timeout counter.
- BUSY:
  - mem_req = 1; mem_* held constant regardless of master inputs.
  - Counter increments each cycle mem_ack = 0.
  - On mem_ack = 1: if read, capture mem_rdata into the owner's rdata; writes leave rdata unchanged. Drop mem_req and go to DONE.
  - If the counter reaches TIMEOUT with no ack: drop mem_req, load owner rdata with 0, set err, go to DONE.
- DONE (one cycle):
  - owner mX_done = 1, mX_err as set;
  - mX_gnt still 1; record owner as last;
  - → IDLE.
- A master must keep req high until its done; it then deasserts req or re-requests. A req still high in IDLE after done starts a new transaction. If the other master is also requesting, round-robin gives that master the grant first.
- Dropping req during BUSY does not abort; the transaction completes.
- mem_ack in IDLE or DONE is ignored.
- Only one of m0_gnt/m1_gnt may be high at a time. Both are low in IDLE.
- Timeout counter width is clog2(TIMEOUT+1) bits. It saturates and does not wrap.

## Timing
- Reset (async, immediate): state IDLE; last owner = 1, so master 0 wins first. All outputs are 0: gnt, done, err, mem_req, mem_we, mem_addr, mem_wdata, rdata.
- Reset asserted mid-BUSY aborts the transaction with no done pulse. mem_req drops asynchronously.
- Latency:
  - req sampled high in IDLE at edge N → mem_req, gnt high after edge N.
  - mem_ack high in cycle M → done/rdata valid after edge M (one cycle).
  - IDLE again after edge M+1.
  - Zero-wait memory (ack in first BUSY cycle): 3 cycles per transaction, req to next grant.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then done+err pulse in the next cycle.
- Ack and timeout in the same cycle: ack wins; err = 0, data captured.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Single read m0: addr=0x40, memory acks after 2 wait cycles with 0xDEADBEEF → mem_req high 3 cycles, mem_addr=0x40, m0_done pulse, m0_rdata=0xDEADBEEF held; m1 outputs stay 0.
- Single write m1: we=1, addr=0x1000, wdata=0x1234 → mem_we=1, mem_wdata=0x1234; m1_done pulse; m1_rdata unchanged.
- Simultaneous, continuous m0_req and m1_req (zero-wait memory) → grants alternate m0, m1, m0, m1; never both gnt high; m0 first after reset.
- No ack, TIMEOUT=15 → mem_req high exactly 15 cycles, then m0_done=m0_err=1 for one cycle, m0_rdata=0, and the arbiter serves the pending m1 next.
- Master changes addr 0x40→0x80 and drops req mid-BUSY → mem_addr stays 0x40 and the transaction completes with done.
- Reset asserted during BUSY → all outputs 0 immediately, no done. After release, both masters requesting → m0 granted first.
